ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

Decode-to-execute pipeline register of the RV32I core that sits directly upstream of the ALU. Captures decoded instructions through a valid/ready handshake and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. While stalled, it snoops write-back so held operands stay current. Drives the ALU's `a`, `b` and `alu_op` inputs from registered state plus the forwarding muxes.

## Interface
- `XLEN`, default 32: datapath width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` / `in_ready` input / output 1: decode handshake.
- `in_pc`, `in_imm`, `in_rs1_val`, `in_rs2_val` input XLEN each: decoded PC, immediate, and register-file read data.
- `in_rs1`, `in_rs2`, `in_rd` input 5 each: register addresses.
- `in_alu_op` input 4: ALU opcode (ADD=0 … SRA=9).
- `in_src_pc`, `in_src_imm`, `in_reg_write` input 1 each: select PC for `a`, select immediate for `b`, and the instruction writes `rd`.
- `flush` input 1: kill the held instruction (branch redirect).
- `exm_we`, `exm_rd`, `exm_data` input 1 / 5 / XLEN: EX/MEM forwarding source.
- `wb_we`, `wb_rd`, `wb_data` input 1 / 5 / XLEN: MEM/WB forwarding source, identical to the register-file write port.
- `out_valid` / `out_ready` output / input 1: execute handshake.
- `alu_a`, `alu_b` output XLEN: ALU operands.
- `alu_op` output 4: registered opcode.
- `store_data` output XLEN: forwarded rs2 value.
- `out_pc`, `out_rd`, `out_reg_write` output XLEN / 5 / 1: carried fields.

## Operation
- `in_ready = !out_valid || out_ready`, combinational. Capture occurs when `in_valid && in_ready`.
- **Capture.** All fields are registered.
  - The register file is not write-through, so each incoming rs value is replaced by `wb_data` when `wb_we`, `wb_rd != 0` and `wb_rd` equals that rs.
- **Hold** (`out_valid && !out_ready`).
  - Each cycle, if `wb_we`, `wb_rd != 0` and `wb_rd` matches a held rs, the held value is overwritten with `wb_data`.
  - Every producer passes through MEM/WB, so this keeps held operands correct.
- **Forward mux.** Output side, combinational, applied per rs:
  - If `exm_we`, `exm_rd == rs` and `rs != 0`, the operand is `exm_data`.
  - Else if the same condition holds on the MEM/WB inputs, the operand is `wb_data`.
  - Else the operand is the held value.
  - x0 is never forwarded.
- `alu_a` = `pc` if `src_pc`, else forwarded rs1.
- `alu_b` = `imm` if `src_imm`, else forwarded rs2.
- `store_data` = forwarded rs2, always.
- **Flush.**
  - `out_valid` is 0 next cycle.
  - Flush beats capture: an instruction handshaken in the same cycle is consumed and dropped.
- **Empty stage.** When `out_valid = 0` and there is no capture, all data registers hold their values; outputs are don't-care but stable.

## Timing
- Latency is 1 cycle from the input handshake to `out_valid`.
- Full throughput: back-to-back capture with `out_ready` tied high.
- Forwarding mux is zero-latency, on the same-cycle path to the ALU.
- Reset:
  - `out_valid = 0`, and all data, address and control registers = 0 (`alu_op` = ADD).
  - `alu_a = alu_b = store_data = 0`.
  - `in_ready = 1` on the first post-reset cycle.
- Reset during hold discards the held instruction; no snoop applies on the reset cycle.
- Simultaneous cases:
  - Advance and capture in one cycle: the new instruction replaces the old one.
  - Snoop and capture in one cycle: the capture-time bypass applies to the new instruction.
- All arithmetic is pass-through; there is no width change, and every selection is a full `XLEN` copy.

## Structure
- Shared package `rv32i_pkg` holds:
  - `XLEN`;
  - `REG_ADDR_W = 5`;
  - `alu_op_e` (4-bit enum, ADD=0 … SRA=9, shared with the ALU);
  - `ex_bundle_t`, the packed struct of captured fields.
- One sub-module, `fwd_mux`, instantiated twice (rs1, rs2). Inputs: rs address, held value, both forwarding sources. Output: the selected value.

## Test plan
- **Reset.** Assert `rst` 2 cycles → `out_valid = 0`, `alu_op = 0`, `alu_a = alu_b = 0`, `in_ready = 1`.
- **Pass-through.** `in_rs1_val = 5`, `in_imm = 7`, `in_src_imm = 1`, `alu_op = ADD`, no forwarding → next cycle `alu_a = 5`, `alu_b = 7`, `out_valid = 1`.
- **Forwarding priority.** Held rs1 = x3 (value 1). With `exm_rd = 3` / `0xAA` and `wb_rd = 3` / `0xBB` both writing → `alu_a = 0xAA`. Drop `exm_we` → `alu_a = 0xBB`.
- **x0.** rs1 = x0, `exm_we = 1`, `exm_rd = 0`, `exm_data = 0xFF` → `alu_a` = held value 0.
- **Stall snoop.** Hold `out_ready = 0` for 3 cycles with rs2 = x4.
  - Cycle 2: `wb_rd = 4`, `wb_data = 0x1234`.
  - Forwarding removed in cycle 3 → `alu_b` still `0x1234`.
  - `in_ready = 0` throughout the stall.
- **Flush vs capture.** `flush = 1` with `in_valid = 1` and `in_ready = 1` → next cycle `out_valid = 0`, and the dropped instruction never appears.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I types for the decode/execute boundary.
// ALU opcodes, register-address width and the EX operand bundle.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    alu_op_e               alu_op;
    logic                  src_pc;
    logic                  src_imm;
    logic                  reg_write;
  } ex_bundle_t;

  // A write port hits rs when it writes a non-zero register equal to rs.
  function automatic logic rf_hit(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs
  );
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand RAW bypass: EX/MEM beats MEM/WB beats held value.
// x0 never takes a forwarded value.
module fwd_mux
  import rv32i_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [W-1:0]          held,
  input  logic                  exm_we,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [W-1:0]          exm_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [W-1:0]          wb_data,
  output logic [W-1:0]          val
);

  always_comb begin
    val = held;
    if (rf_hit(exm_we, exm_rd, rs)) begin
      val = exm_data;
    end else if (rf_hit(wb_we, wb_rd, rs)) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute register feeding the ALU operands.
// Bypasses write-back at capture and snoops it while stalled.
module ex_operand_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [XLEN-1:0]       in_rs1_val,
  input  logic [XLEN-1:0]       in_rs2_val,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [3:0]            in_alu_op,
  input  logic                  in_src_pc,
  input  logic                  in_src_imm,
  input  logic                  in_reg_write,
  input  logic                  flush,
  input  logic                  exm_we,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]       exm_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [3:0]            alu_op,
  output logic [XLEN-1:0]       store_data,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write
);

  ex_bundle_t      q;
  ex_bundle_t      d;
  logic            cap;
  logic            hold;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign in_ready = !out_valid || out_ready;
  assign cap      = in_valid && in_ready;
  assign hold     = out_valid && !out_ready;

  // Register file is not write-through, so the capture bypasses WB itself.
  always_comb begin
    d = q;
    if (cap) begin
      d.pc        = in_pc;
      d.imm       = in_imm;
      d.rs1       = in_rs1;
      d.rs2       = in_rs2;
      d.rd        = in_rd;
      d.alu_op    = alu_op_e'(in_alu_op);
      d.src_pc    = in_src_pc;
      d.src_imm   = in_src_imm;
      d.reg_write = in_reg_write;
      d.rs1_val   = rf_hit(wb_we, wb_rd, in_rs1) ? wb_data : in_rs1_val;
      d.rs2_val   = rf_hit(wb_we, wb_rd, in_rs2) ? wb_data : in_rs2_val;
    end else if (hold) begin
      if (rf_hit(wb_we, wb_rd, q.rs1)) d.rs1_val = wb_data;
      if (rf_hit(wb_we, wb_rd, q.rs2)) d.rs2_val = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else begin
      out_valid <= !flush && (cap || hold);
      q         <= d;
    end
  end

  fwd_mux #(.W(XLEN)) u_fwd_rs1 (
    .rs       (q.rs1),
    .held     (q.rs1_val),
    .exm_we   (exm_we),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .val      (rs1_fwd)
  );

  fwd_mux #(.W(XLEN)) u_fwd_rs2 (
    .rs       (q.rs2),
    .held     (q.rs2_val),
    .exm_we   (exm_we),
    .exm_rd   (exm_rd),
    .exm_data (exm_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .val      (rs2_fwd)
  );

  assign alu_a         = q.src_pc  ? q.pc  : rs1_fwd;
  assign alu_b         = q.src_imm ? q.imm : rs2_fwd;
  assign store_data    = rs2_fwd;
  assign alu_op        = q.alu_op;
  assign out_pc        = q.pc;
  assign out_rd        = q.rd;
  assign out_reg_write = q.reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed cases then random traffic,
// checked against an architectural register-file model.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [3:0]  in_alu_op;
  logic        in_src_pc;
  logic        in_src_imm;
  logic        in_reg_write;
  logic        flush;
  logic        exm_we;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] store_data;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  ex_operand_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rs1_val    (in_rs1_val),
    .in_rs2_val    (in_rs2_val),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .in_alu_op     (in_alu_op),
    .in_src_pc     (in_src_pc),
    .in_src_imm    (in_src_imm),
    .in_reg_write  (in_reg_write),
    .flush         (flush),
    .exm_we        (exm_we),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .wb_we         (wb_we),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .store_data    (store_data),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural register file seen by decode (read data = old value).
  logic [31:0] rf [32];
  assign in_rs1_val = rf[in_rs1];
  assign in_rs2_val = rf[in_rs2];

  // Instruction the stage should currently be presenting.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_imm;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;
  logic [4:0]  m_rd;
  logic [3:0]  m_op;
  logic        m_spc;
  logic        m_simm;
  logic        m_rw;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Newest value of rs as the ALU must see it this cycle.
  function automatic logic [31:0] opnd(input logic [4:0] rs);
    if (rs != 0 && exm_we && exm_rd == rs) return exm_data;
    if (rs != 0 && wb_we && wb_rd == rs) return wb_data;
    return rf[rs];
  endfunction

  task automatic half();
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
    if (m_valid) begin
      chk("alu_a", alu_a, m_spc ? m_pc : opnd(m_rs1));
      chk("alu_b", alu_b, m_simm ? m_imm : opnd(m_rs2));
      chk("store_data", store_data, opnd(m_rs2));
      chk("alu_op", {28'd0, alu_op}, {28'd0, m_op});
      chk("out_pc", out_pc, m_pc);
      chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      chk("out_rw", {31'd0, out_reg_write}, {31'd0, m_rw});
    end
  endtask

  task automatic edge_();
    logic fire;
    @(posedge clk);
    #1;
    fire = in_valid && (!m_valid || out_ready);
    if (rst) begin
      m_valid = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (fire) begin
      m_valid = 1'b1;
      m_pc    = in_pc;
      m_imm   = in_imm;
      m_rs1   = in_rs1;
      m_rs2   = in_rs2;
      m_rd    = in_rd;
      m_op    = in_alu_op;
      m_spc   = in_src_pc;
      m_simm  = in_src_imm;
      m_rw    = in_reg_write;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_we && wb_rd != 0) rf[wb_rd] = wb_data;
  endtask

  task automatic cyc();
    half();
    edge_();
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic spc, input logic simm);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = 5'd5;
    in_imm       = imm;
    in_alu_op    = 4'd0;
    in_src_pc    = spc;
    in_src_imm   = simm;
    in_reg_write = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    rf[1] = 32'd5;
    rf[3] = 32'd1;
    rf[4] = 32'h55;
    m_valid = 1'b0;
    m_pc = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_op = 0; m_spc = 0; m_simm = 0; m_rw = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_pc = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_alu_op = 0; in_src_pc = 0; in_src_imm = 0; in_reg_write = 0;
    exm_we = 0; exm_rd = 0; exm_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;

    edge_();
    edge_();
    rst = 1'b0;
    half();
    chk("rst_op", {28'd0, alu_op}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_sd", store_data, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    edge_();

    issue(32'h100, 5'd1, 5'd2, 32'd7, 1'b0, 1'b1);
    cyc();
    in_valid = 1'b0;
    half();
    chk("pt_a", alu_a, 32'd5);
    chk("pt_b", alu_b, 32'd7);
    chk("pt_v", {31'd0, out_valid}, 32'd1);
    edge_();

    issue(32'h104, 5'd3, 5'd0, 32'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    exm_we = 1; exm_rd = 5'd3; exm_data = 32'hAA;
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'hBB;
    half();
    chk("fwd_exm", alu_a, 32'hAA);
    edge_();
    exm_we = 0;
    half();
    chk("fwd_wb", alu_a, 32'hBB);
    edge_();
    wb_we = 0;
    out_ready = 1'b1;
    cyc();

    issue(32'h108, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    exm_we = 1; exm_rd = 5'd0; exm_data = 32'hFF;
    half();
    chk("x0_a", alu_a, 32'd0);
    chk("x0_sd", store_data, 32'd0);
    edge_();
    exm_we = 0;

    issue(32'h10C, 5'd1, 5'd4, 32'd0, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    half();
    chk("st_rdy1", {31'd0, in_ready}, 32'd0);
    edge_();
    wb_we = 1; wb_rd = 5'd4; wb_data = 32'h1234;
    half();
    chk("st_b2", alu_b, 32'h1234);
    chk("st_rdy2", {31'd0, in_ready}, 32'd0);
    edge_();
    wb_we = 0;
    half();
    chk("st_b3", alu_b, 32'h1234);
    chk("st_rdy3", {31'd0, in_ready}, 32'd0);
    edge_();
    out_ready = 1'b1;
    cyc();

    issue(32'hDEAD0, 5'd1, 5'd2, 32'd9, 1'b0, 1'b0);
    flush = 1'b1;
    half();
    chk("fl_rdy", {31'd0, in_ready}, 32'd1);
    edge_();
    flush = 1'b0;
    in_valid = 1'b0;
    half();
    chk("fl_v1", {31'd0, out_valid}, 32'd0);
    edge_();
    half();
    chk("fl_v2", {31'd0, out_valid}, 32'd0);
    edge_();

    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom % 64) == 0;
      flush        = ($urandom % 16) == 0;
      in_valid     = ($urandom % 4) != 0;
      out_ready    = ($urandom % 4) != 0;
      in_pc        = $urandom;
      in_imm       = $urandom;
      in_rs1       = 5'($urandom % 8);
      in_rs2       = 5'($urandom % 8);
      in_rd        = 5'($urandom);
      in_alu_op    = 4'($urandom % 10);
      in_src_pc    = ($urandom % 4) == 0;
      in_src_imm   = ($urandom % 3) == 0;
      in_reg_write = 1'($urandom);
      exm_we       = 1'($urandom);
      exm_rd       = 5'($urandom % 8);
      exm_data     = $urandom;
      wb_we        = 1'($urandom);
      wb_rd        = 5'($urandom % 8);
      wb_data      = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
